// File: rtl/measure_display_pkg.sv
// Shared definitions for the measurement display reader: default sizes,
// FSM state encodings and active-low seven-segment patterns {g,f,e,d,c,b,a}.
package measure_display_pkg;

    localparam int NUM_W_DEF   = 14;
    localparam int DIGITS_DEF  = 4;
    localparam int MAX_VAL_DEF = 9999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Non-BCD codes cannot come out of the converter; show them as blank anyway.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/measure_display_seg7_encode.sv
// One BCD digit to active-low seven-segment pattern, purely combinational.
module seg7_encode
    import measure_display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Table lookup; codes A-F map to all segments off.
    always_comb begin
        o_seg = seg_pattern(i_digit);
    end

endmodule

// File: rtl/measure_display.sv
// Measurement display reader: captures num on start, converts it serially
// (shift-add-3) to BCD, and drives four active-low HEX displays.
// Build option: MEAS_DISP_BLANK_EN blanks leading zeros (units always shown).
module measure_display
    import measure_display_pkg::*;
#(
    parameter int NUM_W   = NUM_W_DEF,
    parameter int DIGITS  = DIGITS_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NUM_W-1:0]      num,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [NUM_W-1:0] MAX_V = NUM_W'(MAX_VAL);

    state_t                   r_state;
    logic [NUM_W-1:0]         r_v;
    logic [BCD_W-1:0]         r_scratch;
    logic [BCD_W-1:0]         r_bcd;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ovf;
    logic                     r_ovf_next;
    logic [DIGITS-1:0][6:0]   r_hex;

    // Adjusted scratch without its top bit: that bit is shifted out and the
    // saturated input guarantees it is always zero.
    logic [BCD_W-2:0]         w_adj;
    logic [DIGITS-1:0][6:0]   w_seg;
    logic [DIGITS-1:0][6:0]   w_disp;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == DIGITS - 1) begin : g_top
                assign w_adj[4*gi +: 3] = (r_scratch[4*gi +: 4] >= 4'd5)
                                          ? 3'(r_scratch[4*gi +: 4] + 4'd3)
                                          : r_scratch[4*gi +: 3];
            end else begin : g_low
                assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                          ? r_scratch[4*gi +: 4] + 4'd3
                                          : r_scratch[4*gi +: 4];
            end

            seg7_encode u_enc (
                .i_digit (r_scratch[4*gi +: 4]),
                .o_seg   (w_seg[gi])
            );
        end
    endgenerate

`ifdef MEAS_DISP_BLANK_EN
    // w_zero_from[k]: digits k..DIGITS-1 of the finished result are all zero.
    logic [DIGITS:1] w_zero_from;
    assign w_zero_from[DIGITS] = 1'b1;
    assign w_disp[0] = w_seg[0];
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign w_zero_from[gi] = w_zero_from[gi+1] & (r_scratch[4*gi +: 4] == 4'd0);
            assign w_disp[gi]      = w_zero_from[gi] ? SEG_BLANK : w_seg[gi];
        end
    endgenerate
`else
    assign w_disp = w_seg;
`endif

    // Capture / shift / update sequencer with all outputs registered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_v        <= '0;
            r_scratch  <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_ovf_next <= 1'b0;
            r_hex      <= {DIGITS{SEG_BLANK}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_v        <= (num > MAX_V) ? MAX_V : num;
                        r_ovf_next <= (num > MAX_V);
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= {w_adj, r_v[NUM_W-1]};
                    r_v       <= {r_v[NUM_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(NUM_W - 1)) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_bcd   <= r_scratch;
                    r_ovf   <= r_ovf_next;
                    r_hex   <= w_disp;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign bcd      = r_bcd;
    assign hex0     = r_hex[0];
    assign hex1     = r_hex[1];
    assign hex2     = r_hex[2];
    assign hex3     = r_hex[3];

endmodule

// File: tb/tb_measure_display.sv
// Directed bench for measure_display: latency, BCD result, HEX patterns,
// overflow saturation, ignored start, mid-conversion reset, held-start sweep.
module tb_measure_display;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic [13:0] num    = '0;
    logic        start  = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [27:0] H_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [27:0] H_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] H_9999  = {7'h10, 7'h10, 7'h10, 7'h10};
`ifdef MEAS_DISP_BLANK_EN
    localparam logic [27:0] H_0042  = {7'h7F, 7'h7F, 7'h19, 7'h24};
    localparam logic [27:0] H_0007  = {7'h7F, 7'h7F, 7'h7F, 7'h78};
`else
    localparam logic [27:0] H_0042  = {7'h40, 7'h40, 7'h19, 7'h24};
    localparam logic [27:0] H_0007  = {7'h40, 7'h40, 7'h40, 7'h78};
`endif

    measure_display dut (
        .clock    (clock),
        .resetn   (resetn),
        .num      (num),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (bcd),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] hex_all();
        return {hex3, hex2, hex1, hex0};
    endfunction

    function automatic logic [15:0] dec_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [27:0] exp_hex(input logic [15:0] b);
        logic [27:0] r;
        logic [3:0]  d;
        logic [6:0]  s;
`ifdef MEAS_DISP_BLANK_EN
        bit lead;
        lead = 1'b1;
`endif
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            d = b[4*i +: 4];
            s = SEG_TAB[d];
`ifdef MEAS_DISP_BLANK_EN
            if (lead && d == 4'd0 && i != 0) s = 7'h7F;
            if (d != 4'd0) lead = 1'b0;
`endif
            r[7*i +: 7] = s;
        end
        return r;
    endfunction

    // Called at the negedge just after the accepting edge; returns edges to done.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic do_conv(input string tag, input logic [13:0] n, input logic [15:0] e_bcd,
                           input logic [27:0] e_hex, input logic e_ovf);
        int lat, bc;
        @(negedge clock);
        num   = n;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, bc);
        chk({tag, " latency"}, lat, 15);
        chk({tag, " busy cycles"}, bc, 15);
        chk({tag, " busy at done"}, busy, 1'b0);
        chk({tag, " bcd"}, bcd, e_bcd);
        chk({tag, " hex"}, hex_all(), e_hex);
        chk({tag, " overflow"}, overflow, e_ovf);
        @(negedge clock);
        chk({tag, " done width"}, done, 1'b0);
        $display("conv %s num=%0d bcd=%h ovf=%0b lat=%0d", tag, n, bcd, overflow, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, dones;
        int vals[$];

        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        chk("reset bcd", bcd, 16'h0000);
        chk("reset hex", hex_all(), H_BLANK);
        @(negedge clock);
        resetn = 1'b1;

        do_conv("t1234", 14'd1234, 16'h1234, H_1234, 1'b0);
        do_conv("t16383", 14'd16383, 16'h9999, H_9999, 1'b1);
        do_conv("t42", 14'd42, 16'h0042, H_0042, 1'b0);
        do_conv("t9999", 14'd9999, 16'h9999, H_9999, 1'b0);
        do_conv("t10000", 14'd10000, 16'h9999, H_9999, 1'b1);

        // Reset after eight shifts of a conversion.
        @(negedge clock);
        num   = 14'd1234;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst hex", hex_all(), H_BLANK);
        chk("midrst bcd", bcd, 16'h0000);
        chk("midrst overflow", overflow, 1'b0);
        dones = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) dones++;
        end
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("midrst no done", dones, 0);
        $display("reset mid-conversion dones=%0d", dones);
        do_conv("postrst", 14'd1234, 16'h1234, H_1234, 1'b0);

        do_conv("t7", 14'd7, 16'h0007, H_0007, 1'b0);

        // Second start while busy, with a new num, must be ignored.
        @(negedge clock);
        num   = 14'd1234;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        num   = 14'd555;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, bc);
        chk("ignore latency", lat + 5, 15);
        chk("ignore bcd", bcd, 16'h1234);
        chk("ignore hex", hex_all(), H_1234);
        dones = 0;
        repeat (24) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("ignore single done", dones, 0);
        $display("conv ignore num=1234 bcd=%h extra_dones=%0d", bcd, dones);

        // Held-start sweep: one conversion every 16 cycles.
        for (int v = 0; v < 300; v++) vals.push_back(v);
        for (int v = 9990; v <= 9999; v++) vals.push_back(v);
        @(negedge clock);
        num   = 14'(vals[0]);
        start = 1'b1;
        @(negedge clock);
        for (int i = 0; i < vals.size(); i++) begin
            wait_done(lat, bc);
            if (i + 1 < vals.size()) num = 14'(vals[i+1]);
            else start = 1'b0;
            chk("sweep period", lat + 1, 16);
            chk("sweep bcd", bcd, dec_bcd(vals[i]));
            chk("sweep hex", hex_all(), exp_hex(dec_bcd(vals[i])));
            chk("sweep overflow", overflow, 1'b0);
            $display("sweep num=%0d bcd=%h", vals[i], bcd);
            @(negedge clock);
        end
        repeat (20) @(negedge clock);
        chk("sweep idle busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
